// File: rtl/hs_elastic_pipe.sv
`timescale 1ns / 1ps
// Elastic FIFO buffer with req/ack handshakes on both faces (4-phase RTZ or 2-phase
// transition), input synchronisers, occupancy reporting and a flush that spares the offered entry.
module hs_elastic_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TWO_PHASE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_req,
  output logic                   in_ack,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_req,
  input  logic                   out_ack,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {OutIdle, OutWait, OutRtz} out_st_e;

  logic rq_s, ak_s;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign rq_s = in_req;
    assign ak_s = out_ack;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] rq_sync_q, rq_sync_d;
    logic [SYNC_STAGES-1:0] ak_sync_q, ak_sync_d;

    always_comb begin
      rq_sync_d = SYNC_STAGES'({rq_sync_q, in_req});
      ak_sync_d = SYNC_STAGES'({ak_sync_q, out_ack});
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rq_sync_q <= '0;
        ak_sync_q <= '0;
      end else begin
        rq_sync_q <= rq_sync_d;
        ak_sync_q <= ak_sync_d;
      end
    end

    assign rq_s = rq_sync_q[SYNC_STAGES-1];
    assign ak_s = ak_sync_q[SYNC_STAGES-1];
  end

  logic             in_ack_q, in_ack_d;
  logic             out_req_q, out_req_d;
  out_st_e          out_st_q, out_st_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic          push, pop, keep, full_w, empty_w;
  logic [AW-1:0] waddr;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Input face. In 4-phase mode in_ack_q doubles as the IDLE(0)/HOLD(1) state.
  always_comb begin
    in_ack_d = in_ack_q;
    push     = 1'b0;
    if (TWO_PHASE != 0) begin
      if ((rq_s != in_ack_q) && !full_w) begin
        push     = 1'b1;
        in_ack_d = rq_s;
      end
    end else if (!in_ack_q) begin
      if (rq_s && !full_w) begin
        push     = 1'b1;
        in_ack_d = 1'b1;
      end
    end else if (!rq_s) begin
      in_ack_d = 1'b0;
    end
  end

  // Output face. No new offer is made on a flush edge: the head is being discarded.
  always_comb begin
    out_st_d   = out_st_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    case (out_st_q)
      OutIdle: begin
        if (!empty_w && !flush && ((TWO_PHASE != 0) || !ak_s)) begin
          out_data_d = mem_q[rd_ptr_q];
          out_req_d  = (TWO_PHASE != 0) ? ~out_req_q : 1'b1;
          out_st_d   = OutWait;
        end
      end
      OutWait: begin
        if (TWO_PHASE != 0) begin
          if (ak_s == out_req_q) begin
            pop      = 1'b1;
            out_st_d = OutIdle;
          end
        end else if (ak_s) begin
          pop       = 1'b1;
          out_req_d = 1'b0;
          out_st_d  = OutRtz;
        end
      end
      OutRtz: begin
        if (!ak_s) out_st_d = OutIdle;
      end
      default: out_st_d = OutIdle;
    endcase
  end

  // A flush keeps only an offered entry that is not leaving this edge; a same-edge
  // capture lands directly behind whatever survives.
  always_comb begin
    keep     = (out_st_q == OutWait) && !pop;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    waddr    = flush ? (rd_ptr_d + AW'(keep)) : wr_ptr_q;
    wr_ptr_d = waddr + AW'(push);
    if (flush) begin
      count_d = CW'(keep) + CW'(push);
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
    mem_d = mem_q;
    if (push) mem_d[waddr] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack_q   <= 1'b0;
      out_req_q  <= 1'b0;
      out_st_q   <= OutIdle;
      out_data_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_q      <= '{default: '0};
    end else begin
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_st_q   <= out_st_d;
      out_data_q <= out_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign count    = count_q;
  assign full     = full_w;
  assign empty    = empty_w;

endmodule

// File: doc/hs_elastic_pipe.md
Name: hs_elastic_pipe

Overview:
- Clocked elastic buffer with a req/ack handshake on both faces. Successor to the fixed 16-bit, 3-stage handshake pipeline.
- Width, depth and handshake protocol are parametrised: 4-phase return-to-zero or 2-phase transition.
- Adds input synchronisers, occupancy reporting and flush.
- Sits between asynchronous-style producer and consumer stages of the CPU datapath.

Parameters:
- WIDTH, 16, data bits per entry.
- DEPTH, 4, buffer entries (power of two, ≥2).
- TWO_PHASE, 0, 0 = 4-phase RTZ on both faces, 1 = 2-phase transition signalling.
- SYNC_STAGES, 2, flops on in_req and out_ack before use (0 = used directly).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_req  in  1  producer request.
- in_ack  out  1  acknowledge to producer.
- in_data  in  WIDTH  producer data, stable while request is pending.
- out_req  out  1  request to consumer.
- out_ack  in  1  consumer acknowledge.
- out_data  out  WIDTH  head entry, valid while out_req is pending.
- flush  in  1  synchronous discard of non-offered entries.
- count  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset (rst_n low, async):
  - in_ack=0, out_req=0, out_data=0, count=0, full=0, empty=1.
  - Pointers and synchroniser flops clear.
  - Reset mid-handshake abandons the transfer; the stored entry is lost.
- rq_s and ak_s are in_req and out_ack after SYNC_STAGES flops. Timing below is in edges after rq_s/ak_s change.
- Input face, 4-phase:
  - IN_IDLE: rq_s=1 and !full → capture in_data at the tail, count+1, in_ack←1, go to IN_HOLD.
  - While full, wait in IN_IDLE.
  - IN_HOLD: rq_s=0 → in_ack←0, go to IN_IDLE.
- Input face, 2-phase:
  - rq_s != in_ack and !full → capture, count+1, in_ack←rq_s.
- Output face, 4-phase:
  - OUT_IDLE: !empty and ak_s=0 → out_data←head, out_req←1, go to OUT_WAIT.
  - OUT_WAIT: ak_s=1 → pop head, count−1, out_req←0, go to OUT_RTZ.
  - OUT_RTZ: ak_s=0 → go to OUT_IDLE.
  - A consumer still high on ack blocks the next offer.
- Output face, 2-phase:
  - OUT_IDLE: !empty → out_data←head, out_req←~out_req, go to OUT_WAIT.
  - OUT_WAIT: ak_s==out_req → pop, go to OUT_IDLE.
- Latency:
  - Capture at edge E into an empty buffer → out_req changes at E+1, out_data valid the same edge.
  - Minimum in_req to out_req latency: SYNC_STAGES+2 edges.
- Arithmetic: pointers wrap modulo DEPTH. count is a registered up/down counter.
- Simultaneous events:
  - Push and pop on the same edge: count unchanged.
  - full/empty derive from registered count; a push is refused in a full cycle even if a pop also occurs (push retries next edge).
- out_data holds constant while out_req is pending. Data never changes mid-offer.
- Flush (sampled high at an edge):
  - Discards every stored entry except one currently offered (OUT_WAIT). That entry completes its handshake normally.
  - count becomes 1 if offering, else 0.
  - A capture on the same edge is retained: it is written after the flush, and count includes it.
  - Input handshake state is not disturbed.
- Ordering: strict FIFO, no duplication, no loss except by flush or reset.

Test Plan:
- 4-phase single transfer, SYNC_STAGES=2:
  - Stimulus: in_data=A1A1, raise in_req; after in_ack, drop in_req; consumer acks, then drops ack.
  - Required: in_ack rises 3 edges after in_req; out_req rises 1 edge later with out_data=A1A1; count 0→1→0.
- Fill to full, DEPTH=4, consumer ack held 0:
  - Stimulus: push A1A1, B2B2, C3C3, D4D4, then E5E5.
  - Required: full=1 after the 4th push; the 5th in_ack is withheld. Release consumer → pops in order A1A1..E5E5, E5E5 accepted after the first pop, count returns to 0.
- Simultaneous push/pop at count=2:
  - Stimulus: input capture and output pop on the same edge.
  - Required: count stays 2; order preserved.
- Flush with three entries, head A1A1 in OUT_WAIT:
  - Stimulus: pulse flush.
  - Required: count=1; consumer ack yields A1A1 only; empty=1 afterwards. A push on the flush edge (B2B2) remains and is delivered next.
- TWO_PHASE=1:
  - Stimulus: toggle in_req three times with 1111, 2222, 3333.
  - Required: in_ack toggles match each; out_req toggles three times, each completing when out_ack equals out_req; data delivered in order.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously between edges with count=2 and out_req=1.
  - Required: out_req, in_ack and count go to 0 immediately (before next clk edge); empty=1.
